mdu: RTL
========

# mdu

Multiply/divide unit for the pipelined MIPS core. It sits directly downstream of the datapath's register-file read stage, alongside the ALU. It consumes the rs/rt operand pair and an operation code, and runs mult/multu/div/divu over a fixed multi-cycle latency. It owns the architectural HI/LO registers and raises `busy` so the control unit can stall later mult/div/mfhi/mflo instructions.

## Interface
- `MULT_CYCLES`, 5: cycles `busy` stays high for mult/multu (≥1)
- `DIV_CYCLES`, 10: cycles `busy` stays high for div/divu (≥1)

- `clk` input 1: single clock, rising-edge
- `reset` input 1: asynchronous, active-low reset (asserted when 0)
- `start` input 1: request; sampled on rising edge
- `op` input 3: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved
- `rs` input 32: operand A / dividend / mthi-mtlo source
- `rt` input 32: operand B / divisor
- `busy` output 1: registered; high while an operation is in flight
- `hi` output 32: architectural HI register
- `lo` output 32: architectural LO register

## Operation
- Idle: `busy`=0. The unit accepts `start` only when `busy`=0. A `start` while busy is ignored and does not affect the in-flight operation.
- Accepting mult/multu/div/divu:
  - Capture `rs`, `rt`, and `op` at the edge.
  - Load the down-counter with `MULT_CYCLES` or `DIV_CYCLES`.
  - Set `busy`.
- Busy:
  - The counter decrements every cycle.
  - On the edge where it reaches 0, write `hi`/`lo` from the captured operands and clear `busy` on that same edge.
- mult: the signed 64-bit product goes to {hi,lo}. multu: the unsigned 64-bit product goes to {hi,lo}.
- div: lo = signed quotient truncated toward zero; hi = remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient in lo, remainder in hi.
- Divide by zero (rt=0 at capture): the operation still takes `DIV_CYCLES` with `busy` high, but `hi`/`lo` are left unchanged at completion.
- mthi/mtlo (idle only):
  - Write `rs` into `hi` or `lo` at the accepting edge.
  - `busy` stays 0 and the other register is unchanged.
  - While busy, these ops are ignored like any other start.
- Reserved op 6/7: ignored, no state change.
- Operand inputs are don't-care after the capture edge. Results depend only on the captured values.
- Internal result staging may compute the full result at capture, or iteratively. Only the externally visible timing below is normative.

## Timing
- Reset (`reset`=0, asynchronous): `busy`=0, `hi`=0, `lo`=0, counter cleared, pending operation discarded. This holds even if reset is asserted mid-operation.
- Reset release: the first rising edge with `reset`=1 may accept a `start`.
- Latency: `start` accepted at edge N. `busy`=1 after edge N through edge N+k−1. At edge N+k, `busy`→0 and `hi`/`lo` take the new values, where k is `MULT_CYCLES` or `DIV_CYCLES`.
- Between edge N and edge N+k, `hi`/`lo` still show their previous values.
- Back-to-back: `start` presented at edge N+k (when `busy` is already 0 after N+k) is accepted at edge N+k+1. A start at the same edge as completion is ignored, because `busy` is still 1 before that edge.
- mthi/mtlo: `hi`/`lo` updated one edge after presentation. Zero busy cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The control unit stalls on `busy` OR (`start` AND op in 0–3). The MDU does not generate that stall term itself.

## Test plan
- Reset mid-div:
  - Stimulus: start divu 100/7, then pull `reset` low on cycle 3.
  - Expect `busy`=0, hi=lo=0 immediately (asynchronous).
  - After release, a new mult 3×4 completes with lo=12, hi=0.
- mult signed:
  - Stimulus: rs=0xFFFFFFFE (−2), rt=3, defaults.
  - Expect `busy` high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - multu with the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- div signs and overflow:
  - −7/2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF after exactly 10 busy cycles.
  - 0x80000000/−1 gives lo=0x80000000, hi=0.
  - divu 0xFFFFFFFF/0x10 gives lo=0x0FFFFFFF, hi=0xF.
- Divide by zero:
  - Stimulus: preload hi=0x1234, lo=0x5678 via mthi/mtlo, then div rs=9, rt=0.
  - Expect `busy` for 10 cycles, then hi/lo still 0x1234/0x5678.
- Start while busy:
  - Stimulus: issue mult 2×2, then on each busy cycle issue start with mtlo rs=0xDEAD and div 8/2.
  - Expect all ignored; final lo=4, hi=0.
  - A start on the completion edge is also ignored.
- mthi/mtlo timing:
  - Stimulus: idle mthi rs=0xCAFEBABE.
  - Expect hi updated at the next edge, `busy` never asserts, lo unchanged.
  - Reserved op 6 with start leaves all state unchanged.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit: owns HI/LO, runs mult/multu/div/divu with a fixed
// busy latency, and performs single-cycle mthi/mtlo writes when idle.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic          load, done, wr_hi, wr_lo;
  op_t           op_e;

  logic          is_signed, a_neg, b_neg, write_ok;
  logic [31:0]   a_mag, b_mag, q_mag, r_mag;
  logic [63:0]   prod;
  logic [31:0]   res_hi, res_lo;

  assign op_e = op_t'(op);
  assign busy = (state == S_BUSY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load) begin
        op_q <= op[1:0];
        a_q  <= rs;
        b_q  <= rt;
      end
      if (done && write_ok) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (wr_hi) hi <= rs;
      if (wr_lo) lo <= rs;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    done       = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op_e inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
            load       = 1'b1;
            state_next = S_BUSY;
            cnt_next   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          end
          wr_hi = (op_e == OP_MTHI);
          wr_lo = (op_e == OP_MTLO);
        end
      end
      S_BUSY: begin
        // Completion coincides with the count reaching zero on this edge.
        if (cnt == CW'(1)) begin
          done       = 1'b1;
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Signed division via magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
  always_comb begin
    is_signed = ~op_q[0];
    a_neg     = is_signed & a_q[31];
    b_neg     = is_signed & b_q[31];
    a_mag     = a_neg ? -a_q : a_q;
    b_mag     = b_neg ? -b_q : b_q;
    q_mag     = a_mag / b_mag;
    r_mag     = a_mag % b_mag;
    prod      = {{32{a_neg}}, a_q} * {{32{b_neg}}, b_q};
    write_ok  = !(op_q[1] && (b_q == '0));
    if (op_q[1]) begin
      res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
      res_hi = a_neg ? -r_mag : r_mag;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

endmodule
